// File: rtl/mips_reg_file_pkg.sv
// Shared constants for the MIPS register file: default geometry and the
// encodings of the debug-dump sequencer states.
package mips_reg_file_pkg;

  localparam int MIPS_DATA_W   = 32;
  localparam int MIPS_ADDR_W   = 5;
  localparam int MIPS_NUM_REGS = 32;

  localparam logic [1:0] DUMP_IDLE = 2'd0;
  localparam logic [1:0] DUMP_SCAN = 2'd1;
  localparam logic [1:0] DUMP_DONE = 2'd2;

endpackage

// File: rtl/reg_file_dump_fsm.sv
// Debug dump sequencer: walks every register index once per request and
// presents one registered word per cycle on the dbg_* outputs.
module reg_file_dump_fsm
  import mips_reg_file_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = MIPS_ADDR_W,
  parameter int NUM_REGS = MIPS_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_start_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              dbg_busy_o,
  output logic              dbg_valid_o,
  output logic [ADDR_W-1:0] dbg_idx_o,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic              dbg_done_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Busy stays up through the done-pulse cycle, so a start there is refused.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q & ~done_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      DUMP_IDLE: begin
        if (dbg_start_i && !busy_q) begin
          state_d = DUMP_SCAN;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      DUMP_SCAN: begin
        valid_d = 1'b1;
        idx_d   = cnt_q;
        data_d  = rd_data_i;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) state_d = DUMP_DONE;
      end
      DUMP_DONE: begin
        done_d  = 1'b1;
        state_d = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DUMP_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign rd_addr_o   = cnt_q;
  assign dbg_busy_o  = busy_q;
  assign dbg_valid_o = valid_q;
  assign dbg_idx_o   = idx_q;
  assign dbg_data_o  = data_q;
  assign dbg_done_o  = done_q;

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS register file: one write port, two combinational read ports
// with write bypass and hard-wired zero, plus a sequential debug dump.
module mips_reg_file
  import mips_reg_file_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = MIPS_ADDR_W,
  parameter int NUM_REGS = MIPS_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_start,
  output logic              dbg_busy,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_done
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [ADDR_W-1:0] raddr3;
  logic [DATA_W-1:0] rdata3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Zero check wins over bypass so a discarded r0 write never leaks through.
  assign rdata1 = (raddr1 == '0) ? '0 :
                  (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
  assign rdata3 = (raddr3 == '0) ? '0 :
                  (we && (waddr == raddr3)) ? wdata : regs_q[raddr3];

  reg_file_dump_fsm #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_dump (
    .clk         (clk),
    .rst         (rst),
    .dbg_start_i (dbg_start),
    .rd_addr_o   (raddr3),
    .rd_data_i   (rdata3),
    .dbg_busy_o  (dbg_busy),
    .dbg_valid_o (dbg_valid),
    .dbg_idx_o   (dbg_idx),
    .dbg_data_o  (dbg_data),
    .dbg_done_o  (dbg_done)
  );

endmodule

// File: tb/tb_mips_reg_file.sv
// Bench for mips_reg_file: directed scenarios plus random traffic, all
// checked every cycle against a behavioural register/dump model.
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        dbg_start = 1'b0;
  logic        dbg_busy;
  logic        dbg_valid;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_data;
  logic        dbg_done;

  mips_reg_file dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .dbg_start (dbg_start),
    .dbg_busy  (dbg_busy),
    .dbg_valid (dbg_valid),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data),
    .dbg_done  (dbg_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  bit          m_active = 1'b0;
  int          m_rel = 0;       // edges since the accepted start
  bit          exp_busy = 1'b0;
  bit          exp_valid = 1'b0;
  bit          exp_done = 1'b0;
  logic [4:0]  exp_idx = '0;
  logic [31:0] exp_data = '0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_active  = 1'b0;
      m_rel     = 0;
      exp_busy  = 1'b0;
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end else begin
      bit prev_busy;
      prev_busy = exp_busy;
      if (m_active) begin
        m_rel++;
        exp_valid = (m_rel >= 1 && m_rel <= 32);
        if (exp_valid) begin
          exp_idx  = 5'(m_rel - 1);
          exp_data = m_read(5'(m_rel - 1));
        end
        exp_done = (m_rel == 33);
        exp_busy = (m_rel <= 33);
        if (m_rel >= 34) m_active = 1'b0;
      end else begin
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_busy  = 1'b0;
      end
      if (dbg_start && !prev_busy) begin
        m_active = 1'b1;
        m_rel    = 0;
        exp_busy = 1'b1;
      end
      if (we && waddr != 5'd0) m_regs[waddr] = wdata;
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] cap [32];
  int          n_valid_seen = 0;
  int          n_done_seen  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata1", rdata1, m_read(raddr1));
      chk("rdata2", rdata2, m_read(raddr2));
      chk("dbg_busy", 32'(dbg_busy), 32'(exp_busy));
      chk("dbg_valid", 32'(dbg_valid), 32'(exp_valid));
      chk("dbg_done", 32'(dbg_done), 32'(exp_done));
      if (exp_valid) begin
        chk("dbg_idx", 32'(dbg_idx), 32'(exp_idx));
        chk("dbg_data", dbg_data, exp_data);
      end
      if (dbg_valid) begin
        cap[dbg_idx] = dbg_data;
        n_valid_seen++;
      end
      if (dbg_done) n_done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    n_valid_seen = 0;
    n_done_seen  = 0;
    for (int i = 0; i < 32; i++) cap[i] = 32'hxxxx_xxxx;
  endtask

  task automatic pulse_start();
    dbg_start = 1'b1;
    cyc();
    dbg_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    chk("rst_busy", 32'(dbg_busy), 32'd0);
    chk("rst_valid", 32'(dbg_valid), 32'd0);
    chk("rst_done", 32'(dbg_done), 32'd0);
    chk("rst_idx", 32'(dbg_idx), 32'd0);
    chk("rst_data", dbg_data, 32'd0);

    // all addresses read zero after reset
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      #1;
      chk("rst_rd1", rdata1, 32'd0);
      chk("rst_rd2", rdata2, 32'd0);
      cyc();
    end

    // plain write/read and r0 discard
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    cyc();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    chk("r5_rd1", rdata1, 32'hDEADBEEF);
    chk("r5_rd2", rdata2, 32'hDEADBEEF);
    we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; raddr1 = 5'd0;
    #1;
    chk("r0_bypass", rdata1, 32'd0);
    cyc();
    we = 1'b0;
    #1;
    chk("r0_after", rdata1, 32'd0);

    // same-cycle bypass
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr2 = 5'd7;
    #1;
    chk("bypass_r7", rdata2, 32'hA5A5A5A5);
    cyc();
    we = 1'b0;
    #1;
    chk("held_r7", rdata2, 32'hA5A5A5A5);

    // preload rK = K*0x11 and dump
    for (int k = 1; k < 32; k++) begin
      we = 1'b1; waddr = 5'(k); wdata = 32'(k * 32'h11);
      cyc();
    end
    we = 1'b0;
    clear_obs();
    pulse_start();
    #1;
    chk("dump_busy_n1", 32'(dbg_busy), 32'd1);
    repeat (40) cyc();
    chk("dump_words", 32'(n_valid_seen), 32'd32);
    chk("dump_dones", 32'(n_done_seen), 32'd1);
    chk("dump_w0", cap[0], 32'd0);
    chk("dump_w5", cap[5], 32'h55);
    chk("dump_w31", cap[31], 32'h20F);

    // write during dump lands in the word being sampled; restart ignored
    clear_obs();
    pulse_start();
    repeat (20) cyc();
    we = 1'b1; waddr = 5'd20; wdata = 32'hCAFEF00D;
    cyc();
    we = 1'b0;
    repeat (3) cyc();
    pulse_start();
    repeat (30) cyc();
    chk("dump2_w20", cap[20], 32'hCAFEF00D);
    chk("dump2_w19", cap[19], 32'h143);
    chk("dump2_words", 32'(n_valid_seen), 32'd32);
    chk("dump2_dones", 32'(n_done_seen), 32'd1);

    // async reset mid-dump
    clear_obs();
    pulse_start();
    repeat (11) cyc();
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(dbg_busy), 32'd0);
    chk("abort_valid", 32'(dbg_valid), 32'd0);
    raddr1 = 5'd9; raddr2 = 5'd20;
    #1;
    chk("abort_r9", rdata1, 32'd0);
    chk("abort_r20", rdata2, 32'd0);
    cyc();
    rst = 1'b0;
    repeat (30) cyc();
    chk("abort_no_done", 32'(n_done_seen), 32'd0);
    clear_obs();
    pulse_start();
    repeat (40) cyc();
    chk("redump_words", 32'(n_valid_seen), 32'd32);
    chk("redump_dones", 32'(n_done_seen), 32'd1);
    chk("redump_w5", cap[5], 32'd0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      we     = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      dbg_start = ($urandom_range(0, 30) == 0);
      cyc();
    end
    we = 1'b0;
    dbg_start = 1'b0;
    repeat (40) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
